// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the Lab2 MIPS program-counter and fetch controller.
package pc_fetch_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      ISSUE
   } state_t;

   localparam word_t WORD_BYTES       = 32'd4;
   localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
   // Instruction addresses are word aligned, so the two low bits are always zero.
   localparam word_t ALIGN_MASK       = 32'hFFFF_FFFC;

   // J-type target: top nibble of the sequential PC, then the index as a word address.
   function automatic word_t jump_target(input word_t pc_plus4, input logic [25:0] jump_idx);
      return {pc_plus4[31:28], jump_idx, 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller and imem.
interface pc_fetch_ctrl_if;
   import pc_fetch_pkg::*;

   logic  imem_req_o;
   word_t imem_addr_o;
   logic  imem_ack_i;
   word_t imem_data_i;

   // Fetch controller side: issues requests, receives the instruction word.
   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ack_i,
      input  imem_data_i
   );

   // Memory side: accepts requests and returns data in the ack cycle.
   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ack_i,
      output imem_data_i
   );

endinterface

// File: rtl/pc_fetch_ctrl_branch_target_adder.sv
// Branch target: sequential PC plus the pre-shifted offset, forced to a word address.
// Purely combinational so the later pipelined datapath can drop it into any stage.
module branch_target_adder
   import pc_fetch_pkg::*;
(
   input  word_t base,
   input  word_t offset,
   output word_t target
);

   // Modulo-2^32 add; negative offsets give backward branches via two's complement.
   assign target = (base + offset) & ALIGN_MASK;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch FSM: fetch one word over req/ack, present it
// to decode for one issue cycle (longer when stalled), then redirect or step the PC.
module pc_fetch_ctrl
   import pc_fetch_pkg::*;
#(
   parameter word_t RESET_PC = DEFAULT_RESET_PC
)
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   stall_i,
   input  logic                   branch_i,
   input  word_t                  branch_off_i,
   input  logic                   jump_i,
   input  logic [25:0]            jump_idx_i,
   pc_fetch_ctrl_if.master        imem,
   output word_t                  instr_o,
   output logic                   instr_valid_o,
   output word_t                  pc_o,
   output word_t                  pc_plus4_o
);

   state_t state;
   word_t  branch_target;
   word_t  next_pc;

   // pc_o is the PC register itself; pc_plus4_o is registered alongside it so no
   // output depends combinationally on an input.
   branch_target_adder u_branch_target_adder (
      .base   (pc_plus4_o),
      .offset (branch_off_i),
      .target (branch_target)
   );

   // Redirect priority: jump over branch over sequential.
   always_comb begin
      // NOTE: default first so every path assigns next_pc and no latch is inferred.
      next_pc = pc_plus4_o;
      if (jump_i) begin
         next_pc = jump_target(pc_plus4_o, jump_idx_i);
      end else if (branch_i) begin
         next_pc = branch_target;
      end
   end

   // The fetch address is always the current PC; req alone says whether it is live.
   assign imem.imem_addr_o = pc_o;

   // Fetch FSM with registered outputs; reset discards any ack in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: state and outputs use non-blocking assignments so all flops update together.
      if (rst_i) begin
         state           <= IDLE;
         pc_o            <= RESET_PC;
         pc_plus4_o      <= RESET_PC + WORD_BYTES;
         imem.imem_req_o <= 1'b0;
         instr_o         <= '0;
         instr_valid_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state           <= REQ;
               imem.imem_req_o <= 1'b1;
            end
            REQ: begin
               // Hold req and addr steady until memory accepts.
               if (imem.imem_ack_i) begin
                  instr_o         <= imem.imem_data_i;
                  instr_valid_o   <= 1'b1;
                  imem.imem_req_o <= 1'b0;
                  state           <= ISSUE;
               end
            end
            ISSUE: begin
               // Control inputs only matter on the cycle the instruction leaves ISSUE.
               if (!stall_i) begin
                  pc_o            <= next_pc;
                  pc_plus4_o      <= next_pc + WORD_BYTES;
                  instr_valid_o   <= 1'b0;
                  imem.imem_req_o <= 1'b1;
                  state           <= REQ;
               end
            end
            default: begin
               state           <= IDLE;
               imem.imem_req_o <= 1'b0;
               instr_valid_o   <= 1'b0;
            end
         endcase
      end
   end

endmodule
